// File: rtl/fp_div_sqrt_iter_if.sv
// Handshake and operand/result bundle for the iterative FP divide/sqrt unit.
interface fp_div_sqrt_iter_if #(
   parameter int exp_width  = 8,
   parameter int mant_width = 24
);
   localparam int W = exp_width + mant_width;

   logic         in_valid;
   logic         in_ready;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   round_mode;
   logic         cancel;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic [4:0]   exceptions;
   logic         busy;

   modport master (
      output in_valid, op, a, b, round_mode, cancel, out_ready,
      input  in_ready, out_valid, out, exceptions, busy
   );

   modport slave (
      input  in_valid, op, a, b, round_mode, cancel, out_ready,
      output in_ready, out_valid, out, exceptions, busy
   );
endinterface

// File: rtl/fp_div_sqrt_iter.sv
// Iterative IEEE-754 divide / square root, restoring recurrence with
// bits_per_cycle steps per clock, single rounding at the end, held result.
//
// state | meaning
// IDLE  | waiting for an operation
// ITER  | recurrence running, cnt counts remaining cycles down to 1
// DONE  | result registered, waiting for out_ready
module fp_div_sqrt_iter #(
   parameter int exp_width      = 8,
   parameter int mant_width     = 24,
   parameter int bits_per_cycle = 1
) (
   input logic             clk,
   input logic             rst,
   fp_div_sqrt_iter_if.slave io
);
   localparam int E    = exp_width;
   localparam int M    = mant_width;
   localparam int F    = M - 1;
   localparam int W    = E + M;
   localparam int N    = (M + 2 + bits_per_cycle - 1) / bits_per_cycle;
   localparam int NB   = N * bits_per_cycle;
   localparam int RW   = NB + 3;
   localparam int CW   = $clog2(N + 1);
   localparam int LZW  = $clog2(M);
   localparam int XW   = E + LZW + 3;
   localparam int BIAS = (1 << (E - 1)) - 1;
   localparam int EMAX = (1 << E) - 1;
   localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic logic [LZW-1:0] lzc(input logic [M-1:0] v);
      lzc = '0;
      for (int i = 0; i < M; i++)
         if (v[i]) lzc = LZW'(M - 1 - i);
   endfunction

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic            op_q, sign_q;
   logic [2:0]      rm_q;
   logic [XW-1:0]   exp_q;
   logic [M-1:0]    mb_q;
   logic [RW-1:0]   rem_q, rem_n, rem_sh, trial;
   logic [NB-1:0]   quot_q, quot_n;
   logic [2*NB-1:0] rad_q, rad_n;
   logic [W-1:0]    out_q, res;
   logic [4:0]      exc_q, exc_n;

   logic            sa, sb;
   logic [E-1:0]    ea, eb;
   logic [F-1:0]    fa, fb;
   logic            a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan;
   logic [M-1:0]    ma_raw, mb_raw, ma_n, mb_n;
   logic [LZW-1:0]  lz_a, lz_b;
   logic [XW-1:0]   ue_a, ue_b;

   assign {sa, ea, fa} = io.a;
   assign {sb, eb, fb} = io.b;
   assign a_zero = (ea == '0) && (fa == '0);
   assign b_zero = (eb == '0) && (fb == '0);
   assign a_inf  = (ea == '1) && (fa == '0);
   assign b_inf  = (eb == '1) && (fb == '0);
   assign a_nan  = (ea == '1) && (fa != '0);
   assign b_nan  = (eb == '1) && (fb != '0);
   assign a_snan = a_nan && !fa[F-1];
   assign b_snan = b_nan && !fb[F-1];
   // subnormals are normalised up front so the recurrence always sees a leading 1
   assign ma_raw = {ea != '0, fa};
   assign mb_raw = {eb != '0, fb};
   assign lz_a   = lzc(ma_raw);
   assign lz_b   = lzc(mb_raw);
   assign ma_n   = ma_raw << lz_a;
   assign mb_n   = mb_raw << lz_b;
   assign ue_a   = XW'(ea) + XW'(ea == '0) - XW'(BIAS) - XW'(lz_a);
   assign ue_b   = XW'(eb) + XW'(eb == '0) - XW'(BIAS) - XW'(lz_b);

   logic            accept, spec_hit, sign_init;
   logic [W-1:0]    spec_res;
   logic [4:0]      spec_exc;
   logic [XW-1:0]   exp_init;
   logic [RW-1:0]   rem_init;
   logic [2*NB-1:0] rad_init;

   always_comb begin
      spec_hit  = 1'b1;
      spec_res  = '0;
      spec_exc  = '0;
      sign_init = io.op ? sa : (sa ^ sb);
      if (!io.op) begin
         if (a_nan || b_nan) begin
            spec_res    = QNAN;
            spec_exc[4] = a_snan || b_snan;
         end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res    = QNAN;
            spec_exc[4] = 1'b1;
         end else if (a_inf || b_zero) begin
            spec_res    = {sign_init, {E{1'b1}}, {F{1'b0}}};
            spec_exc[3] = !a_inf;
         end else if (a_zero || b_inf) begin
            spec_res    = {sign_init, {(W-1){1'b0}}};
         end else begin
            spec_hit    = 1'b0;
         end
      end else begin
         if (a_nan) begin
            spec_res    = QNAN;
            spec_exc[4] = a_snan;
         end else if (a_zero) begin
            spec_res    = io.a;
         end else if (sa) begin
            spec_res    = QNAN;
            spec_exc[4] = 1'b1;
         end else if (a_inf) begin
            spec_res    = io.a;
         end else begin
            spec_hit    = 1'b0;
         end
      end
      exp_init = io.op ? {ue_a[XW-1], ue_a[XW-1:1]} : (ue_a - ue_b);
      rem_init = io.op ? '0 : RW'(ma_n);
      // odd exponent: radicand doubled so the halved exponent stays exact
      rad_init = (io.op && ue_a[0]) ? {ma_n, 1'b0, {(2*NB-M-1){1'b0}}}
                                    : {1'b0, ma_n, {(2*NB-M-1){1'b0}}};
   end

   always_comb begin
      rem_n  = rem_q;
      quot_n = quot_q;
      rad_n  = rad_q;
      rem_sh = '0;
      trial  = '0;
      for (int i = 0; i < bits_per_cycle; i++) begin
         if (op_q) begin
            rem_sh = {rem_n[RW-3:0], rad_n[2*NB-1 -: 2]};
            trial  = {1'b0, quot_n, 2'b01};
            rad_n  = rad_n << 2;
         end else begin
            rem_sh = {rem_n[RW-2:0], 1'b0};
            trial  = RW'({mb_q, 1'b0});
         end
         if (rem_sh >= trial) begin
            rem_n  = rem_sh - trial;
            quot_n = {quot_n[NB-2:0], 1'b1};
         end else begin
            rem_n  = rem_sh;
            quot_n = {quot_n[NB-2:0], 1'b0};
         end
      end
   end

   logic [NB-1:0]  qn;
   logic [NB:0]    ext;
   logic [XW-1:0]  be, sh;
   logic [M-1:0]   mant;
   logic [W-2:0]   sum;
   logic           tiny, g, s, inexact, inc, ovf, to_inf;

   always_comb begin
      qn      = quot_n[NB-1] ? quot_n : (quot_n << 1);
      be      = exp_q + XW'(BIAS) - XW'(!quot_n[NB-1]);
      tiny    = be[XW-1] || (be == '0);
      sh      = XW'(1) - be;
      ext     = {qn, rem_n != '0};
      if (tiny)
         for (int i = 0; i <= NB; i++)
            if (XW'(i) < sh) ext = {1'b0, ext[NB:2], ext[1] | ext[0]};
      mant    = ext[NB -: M];
      g       = ext[NB-M];
      s       = |ext[NB-M-1:0];
      inexact = g | s;
      case (rm_q)
         3'd1:    begin inc = 1'b0;              to_inf = 1'b0;    end
         3'd2:    begin inc = sign_q & inexact;  to_inf = sign_q;  end
         3'd3:    begin inc = !sign_q & inexact; to_inf = !sign_q; end
         3'd4:    begin inc = g;                 to_inf = 1'b1;    end
         default: begin inc = g & (s | mant[0]); to_inf = 1'b1;    end
      endcase
      // a rounding carry out of the fraction bumps the exponent field directly
      sum = {tiny ? {E{1'b0}} : be[E-1:0], mant[F-1:0]} + (W-1)'(inc);
      ovf = (!be[XW-1] && (be >= XW'(EMAX))) || (sum[W-2 -: E] == '1);
      if (ovf) begin
         res   = to_inf ? {sign_q, {E{1'b1}}, {F{1'b0}}}
                        : {sign_q, E'(EMAX - 1), {F{1'b1}}};
         exc_n = 5'b00101;
      end else begin
         res   = {sign_q, sum};
         exc_n = {3'b000, tiny & inexact, inexact};
      end
   end

   assign io.in_ready   = !rst && !io.cancel &&
                          ((state == S_IDLE) || ((state == S_DONE) && io.out_ready));
   assign accept        = io.in_valid && io.in_ready;
   assign io.out_valid  = (state == S_DONE);
   assign io.busy       = (state != S_IDLE);
   assign io.out        = out_q;
   assign io.exceptions = exc_q;

   always_ff @(posedge clk) begin
      if (rst || io.cancel) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op_q   <= 1'b0;
         sign_q <= 1'b0;
         rm_q   <= '0;
         exp_q  <= '0;
         mb_q   <= '0;
         rem_q  <= '0;
         quot_q <= '0;
         rad_q  <= '0;
         out_q  <= '0;
         exc_q  <= '0;
      end else if (accept) begin
         op_q   <= io.op;
         sign_q <= sign_init;
         rm_q   <= io.round_mode;
         exp_q  <= exp_init;
         mb_q   <= mb_n;
         rem_q  <= rem_init;
         quot_q <= '0;
         rad_q  <= rad_init;
         if (spec_hit) begin
            state <= S_DONE;
            out_q <= spec_res;
            exc_q <= spec_exc;
         end else begin
            state <= S_ITER;
            cnt   <= CW'(N);
         end
      end else if (state == S_ITER) begin
         rem_q  <= rem_n;
         quot_q <= quot_n;
         rad_q  <= rad_n;
         cnt    <= cnt - 1'b1;
         if (cnt == CW'(1)) begin
            state <= S_DONE;
            out_q <= res;
            exc_q <= exc_n;
         end
      end else if ((state == S_DONE) && io.out_ready) begin
         state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_fp_div_sqrt_iter.sv
// Directed bench for fp_div_sqrt_iter: one instance per bits_per_cycle setting,
// expected results queued at issue and checked when the unit presents them.
module tb_fp_div_sqrt_iter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp_div_sqrt_iter_if #(.exp_width(8), .mant_width(24)) io1 ();
   fp_div_sqrt_iter_if #(.exp_width(8), .mant_width(24)) io2 ();

   fp_div_sqrt_iter #(.exp_width(8), .mant_width(24), .bits_per_cycle(1)) dut1 (
      .clk(clk), .rst(rst), .io(io1.slave));
   fp_div_sqrt_iter #(.exp_width(8), .mant_width(24), .bits_per_cycle(2)) dut2 (
      .clk(clk), .rst(rst), .io(io2.slave));

   logic        sel, in_valid, op, cancel, out_ready;
   logic [31:0] a, b;
   logic [2:0]  round_mode;

   assign io1.in_valid   = in_valid && !sel;
   assign io2.in_valid   = in_valid && sel;
   assign io1.out_ready  = sel ? 1'b1 : out_ready;
   assign io2.out_ready  = sel ? out_ready : 1'b1;
   assign io1.cancel     = cancel && !sel;
   assign io2.cancel     = cancel && sel;
   assign io1.op = op;  assign io1.a = a;  assign io1.b = b;  assign io1.round_mode = round_mode;
   assign io2.op = op;  assign io2.a = a;  assign io2.b = b;  assign io2.round_mode = round_mode;

   logic        in_ready_s, out_valid_s, busy_s;
   logic [31:0] out_s;
   logic [4:0]  exc_s;
   assign in_ready_s  = sel ? io2.in_ready   : io1.in_ready;
   assign out_valid_s = sel ? io2.out_valid  : io1.out_valid;
   assign busy_s      = sel ? io2.busy       : io1.busy;
   assign out_s       = sel ? io2.out        : io1.out;
   assign exc_s       = sel ? io2.exceptions : io1.exceptions;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  exc;
   } exp_t;
   exp_t sbq[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   task automatic issue(input logic s, input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [2:0] rm, input logic [31:0] eres, input logic [4:0] eexc,
                        input string tag);
      @(negedge clk);
      sel = s; op = o; a = av; b = bv; round_mode = rm; in_valid = 1'b1;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready_s), 32'd1);
      sbq.push_back('{res: eres, exc: eexc});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic collect(input int lat, input string tag);
      int   cyc;
      exp_t e;
      cyc = 1;
      #1;
      while (!out_valid_s && cyc < 100) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(lat));
      e = (sbq.size() > 0) ? sbq.pop_front() : '{res: 32'hxxxxxxxx, exc: 5'bxxxxx};
      check({tag, "_out"}, out_s, e.res);
      check({tag, "_exc"}, 32'(exc_s), 32'(e.exc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   highs;
      exp_t e;
      rst = 1'b1; sel = 1'b0; in_valid = 1'b0; op = 1'b0; cancel = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; round_mode = 3'd0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready_low", 32'(in_ready_s), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid_s), 32'd0);
      check("rst_out", out_s, 32'd0);
      check("rst_exc", 32'(exc_s), 32'd0);
      check("rst_busy", 32'(busy_s), 32'd0);
      check("rst_in_ready_high", 32'(in_ready_s), 32'd1);

      // bits_per_cycle = 1: normal cases
      issue(0, 0, 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, "div_6_2");
      collect(27, "div_6_2");
      issue(0, 0, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01, "div_1_3_rne");
      collect(27, "div_1_3_rne");
      issue(0, 0, 32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'h01, "div_1_3_rtz");
      collect(27, "div_1_3_rtz");
      issue(0, 0, 32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'h01, "div_m1_3_rdn");
      collect(27, "div_m1_3_rdn");
      issue(0, 1, 32'h40000000, 32'h0,        3'd0, 32'h3FB504F3, 5'h01, "sqrt_2");
      collect(27, "sqrt_2");
      issue(0, 1, 32'h40800000, 32'h0,        3'd0, 32'h40000000, 5'h00, "sqrt_4");
      collect(27, "sqrt_4");
      issue(0, 0, 32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 5'h05, "div_ovf");
      collect(27, "div_ovf");
      issue(0, 0, 32'h00800000, 32'h40000000, 3'd0, 32'h00400000, 5'h00, "div_subn");
      collect(27, "div_subn");

      // specials
      issue(0, 0, 32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'h08, "div_1_0");
      collect(1, "div_1_0");
      issue(0, 0, 32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 5'h10, "div_0_0");
      collect(1, "div_0_0");
      issue(0, 1, 32'hBF800000, 32'h0,        3'd0, 32'h7FC00000, 5'h10, "sqrt_m1");
      collect(1, "sqrt_m1");
      issue(0, 1, 32'h80000000, 32'h0,        3'd0, 32'h80000000, 5'h00, "sqrt_m0");
      collect(1, "sqrt_m0");

      // bits_per_cycle = 2
      issue(1, 0, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01, "r2_div_1_3_rne");
      collect(14, "r2_div_1_3_rne");
      issue(1, 0, 32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'h01, "r2_div_1_3_rtz");
      collect(14, "r2_div_1_3_rtz");
      issue(1, 1, 32'h00000001, 32'h0,        3'd0, 32'h1A3504F3, 5'h01, "r2_sqrt_minsub");
      collect(14, "r2_sqrt_minsub");
      issue(1, 0, 32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'h08, "r2_div_1_0");
      collect(1, "r2_div_1_0");

      // backpressure then back-to-back accept
      out_ready = 1'b0;
      issue(0, 0, 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, "bp");
      highs = 1;
      #1;
      while (!out_valid_s && highs < 100) begin @(negedge clk); #1; highs++; end
      check("bp_latency", 32'(highs), 32'd27);
      a = 32'h3F800000; b = 32'h00000000; op = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check("bp_out_stable", out_s, 32'h40400000);
         check("bp_out_valid", 32'(out_valid_s), 32'd1);
         check("bp_in_ready_low", 32'(in_ready_s), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("b2b_in_ready", 32'(in_ready_s), 32'd1);
      e = (sbq.size() > 0) ? sbq.pop_front() : '{res: 32'hxxxxxxxx, exc: 5'bxxxxx};
      check("bp_out", out_s, e.res);
      check("bp_exc", 32'(exc_s), 32'(e.exc));
      sbq.push_back('{res: 32'h7F800000, exc: 5'h08});
      @(negedge clk);
      in_valid = 1'b0;
      collect(1, "b2b");

      // cancel mid-ITER together with a new in_valid
      issue(0, 0, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01, "cancel");
      void'(sbq.pop_back());
      repeat (5) @(negedge clk);
      #1;
      check("cancel_busy_before", 32'(busy_s), 32'd1);
      a = 32'h40C00000; b = 32'h40000000; cancel = 1'b1; in_valid = 1'b1;
      #1;
      check("cancel_in_ready", 32'(in_ready_s), 32'd0);
      @(negedge clk);
      cancel = 1'b0; in_valid = 1'b0;
      #1;
      check("cancel_idle", 32'(busy_s), 32'd0);
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid_s) highs++;
         @(negedge clk);
         #1;
      end
      check("cancel_no_result", 32'(highs), 32'd0);

      // reset mid-ITER
      issue(0, 0, 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, "pre_rst");
      collect(27, "pre_rst");
      issue(0, 1, 32'h40000000, 32'h0, 3'd0, 32'h3FB504F3, 5'h01, "rst_mid");
      sbq.delete();
      repeat (4) @(negedge clk);
      #1;
      check("rst_mid_busy", 32'(busy_s), 32'd1);
      check("rst_mid_out_prev", out_s, 32'h40400000);
      rst = 1'b1;
      #1;
      check("rst_mid_in_ready", 32'(in_ready_s), 32'd0);
      @(negedge clk);
      #1;
      check("rst_mid_out_valid", 32'(out_valid_s), 32'd0);
      check("rst_mid_out", out_s, 32'd0);
      check("rst_mid_exc", 32'(exc_s), 32'd0);
      check("rst_mid_busy_clr", 32'(busy_s), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("rst_mid_in_ready_back", 32'(in_ready_s), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fp_div_sqrt_iter.md
# fp_div_sqrt_iter

Iterative IEEE-754 floating-point divide/square-root unit with a configurable number of quotient/root bits per cycle. It has an output-side valid/ready handshake, so a result is held until the consumer takes it. It sits in the FPU execute stage beside the multiply-add unit. It reuses the existing operand-recoding (`exponent`), classification (`mac_spec_check`) and rounding (`round_excep`) submodules.

## Interface
- `exp_width`, 8, exponent field width
- `mant_width`, 24, significand width including the hidden bit
- `bits_per_cycle`, 1, quotient/root bits produced per iteration; legal values are 1 and 2
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operands and op presented
- `in_ready`  out  1  unit can accept an operation this cycle
- `op`  in  1  0 = a/b, 1 = sqrt(a); b is ignored when op=1
- `a`, `b`  in  exp_width+mant_width  IEEE operands
- `round_mode`  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
- `cancel`  in  1  synchronous abort of the in-flight operation
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts the result
- `out`  out  exp_width+mant_width  rounded result
- `exceptions`  out  5  {NV, DZ, OF, UF, NX}
- `busy`  out  1  state is not IDLE

## Operation
- States: IDLE, ITER, DONE.
- Accept: occurs when in_valid && in_ready && !cancel. On accept, capture op, sign, exponent, divisor/radicand significand and round_mode.
- IDLE → ITER: accepted operation with finite nonzero operands. Sqrt additionally requires a positive operand.
- IDLE → DONE: accepted special case. The special result is registered directly.
- ITER: a down-counter starts at N = ceil((mant_width+2)/bits_per_cycle) and decrements once per cycle.
  - Each cycle retires bits_per_cycle restoring steps. Each step is rem<<1 minus the trial term; a non-negative difference sets the bit and replaces rem.
  - When the counter reaches 1, the rounded result and flags are registered and the state moves to DONE.
- Divide:
  - Exponent = expA − expB, saturated as in the existing divider.
  - Trial term = divisor<<1.
- Sqrt:
  - Unbiased exponent is halved (floor). When the unbiased exponent is odd, the radicand is shifted left by 1 before iteration.
  - Trial term = (root<<2 | 1) at the current bit position.
- Sticky bit = (final remainder ≠ 0), appended below the mant_width+2 result bits and fed to `round_excep` with the captured round_mode.
- Divide specials:
  - NaN operand → canonical qNaN; NV only when an operand is sNaN.
  - 0/0 and inf/inf → qNaN with NV.
  - finite nonzero /0 → signed inf with DZ.
  - inf/finite → inf; finite/inf → signed 0.
- Sqrt specials:
  - −0 → −0.
  - +inf → +inf.
  - negative nonzero, including −inf → qNaN with NV.
  - qNaN → qNaN; sNaN → qNaN with NV.
- DONE: out/exceptions are stable while out_valid && !out_ready.
  - DONE → IDLE on out_ready.
  - DONE → ITER/DONE directly when out_ready and a new accept occur in the same cycle (back-to-back).
- in_ready = !cancel && (IDLE || (DONE && out_ready)).
- cancel: from any state, next state is IDLE.
  - The result is discarded, out_valid drops the next cycle, and no partial result is presented.
  - cancel beats in_valid in the same cycle.

## Timing
- Reset:
  - state IDLE, all datapath registers 0.
  - out_valid=0, out=0, exceptions=0, busy=0.
  - in_ready=1 from the first cycle after rst deasserts; in_ready=0 while rst is high.
- Normal-case latency: accept at edge t; out_valid is high from cycle t+N+1.
  - bits_per_cycle=1: N=26 for 24-bit significands.
  - bits_per_cycle=2: N=13.
- Special-case latency: out_valid is high in cycle t+1.
- Throughput: one operation per N+1 cycles with out_ready held high; no bubble between results.
- rst mid-operation: same as cancel. All state clears on the next edge; flags are not preserved.

## Test plan
- Divide 6.0 by 2.0 (a=0x40C00000, b=0x40000000, RNE, bits_per_cycle=1) → out=0x40400000, exceptions=0, out_valid exactly 27 cycles after accept.
- 1.0/3.0 (0x3F800000/0x40400000):
  - RNE → 0x3EAAAAAB, NX=1.
  - RTZ → 0x3EAAAAAA.
  - Repeat with bits_per_cycle=2 → same values, out_valid 14 cycles after accept.
- sqrt(2.0) (0x40000000, RNE) → 0x3FB504F3, NX=1; sqrt(4.0) → 0x40000000, exceptions=0.
- Specials, each with out_valid 1 cycle after accept:
  - 1.0/+0 → 0x7F800000, DZ.
  - 0/0 → 0x7FC00000, NV.
  - sqrt(−1.0) → 0x7FC00000, NV.
  - sqrt(−0) → 0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out stable, in_ready=0. Then raise out_ready together with a new in_valid → the new operation is accepted in that cycle.
- Cancel and reset:
  - Assert cancel mid-ITER together with in_valid → no accept, IDLE next cycle, out_valid never rises for the cancelled operation.
  - Assert rst mid-ITER → all outputs return to reset values on the next cycle.
